fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Program-counter sequencer and instruction-fetch controller for the 8-bit-instruction CPU.
- Acts as the initiator toward the combinational instruction ROM: drives `pc`, consumes the ROM's decoded `opcode`, `format` and `jmp_loc` in the same cycle, and registers the next PC.
- Resolves sequential, jump, conditional-branch and halt flow. The branch condition comes from the execute-stage comparator.

Parameters:
- PC_W, 16, width of pc and jmp_loc
- START_ADDR, 16'd0, PC value loaded on reset and on every (re)start

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; leaves IDLE/HALTED and begins fetch at START_ADDR
- stall  in  1  hold current pc; the instruction is not retired this cycle
- opcode  in  4  opcode field returned by the ROM for the current pc
- format  in  2  format field returned by the ROM (C=00, I=01, M=10, X=11)
- jmp_loc  in  PC_W  target address returned by the ROM
- branch_taken  in  1  comparator result for the current branch instruction
- pc  out  PC_W  address presented to the ROM (registered)
- instr_valid  out  1  current ROM output is a live instruction to execute
- halted  out  1  sequencer is in HALTED
- done  out  1  one-cycle pulse on entry to HALTED
- instr_count  out  32  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=START_ADDR, instr_valid=0, halted=0, done=0, instr_count=0.
- States: IDLE, RUN, HALTED. The state register is updated on the rising clk edge.
- IDLE:
  - instr_valid=0; pc held at START_ADDR.
  - start=1 -> RUN next cycle with pc=START_ADDR.
- RUN:
  - instr_valid = ~stall.
  - Each unstalled cycle retires the instruction at pc. Next pc is chosen by first match:
    1. opcode=HALT(1110) -> pc holds, go to HALTED.
    2. opcode=JMP(0010) -> pc=jmp_loc.
    3. opcode in {BNE 1010, BEQ 1011, BLT 1100, BLS 1111} and branch_taken=1 -> pc=jmp_loc.
    4. Otherwise -> pc=pc+1, modulo 2^PC_W.
- Stall:
  - stall=1 in RUN: pc, state and instr_count hold.
  - stall has priority over HALT, JMP and taken branches.
- Ignored inputs:
  - branch_taken is ignored for non-branch opcodes.
  - format is used only for the X_FORM check: format=11 with opcode other than HALT is treated as sequential.
- Latency: the ROM is combinational, so the decode for pc is available in the same cycle. A redirect takes effect on the next edge, with zero bubble cycles.
- Wrap-around: pc=16'hFFFF with a sequential op -> 16'h0000. No flag is raised.
- HALTED:
  - halted=1, instr_valid=0, pc frozen at the HALT address.
  - done=1 only on the first HALTED cycle.
  - start=1 -> RUN with pc=START_ADDR. instr_count is not cleared.
- start while in RUN is ignored.
- Reset asserted mid-RUN returns to IDLE immediately; there is no partial retire.
- X/undefined opcode (the ROM emits x for unmapped pc) is treated as sequential; simulation issues $warning.

Optional Feature:
- Macro: FETCH_INSTR_COUNT_EN.
- Defined: instr_count increments by 1 on every retired (unstalled RUN) instruction, including JMP, branches and HALT. It saturates at 32'hFFFFFFFF.
- Undefined: instr_count is tied to 32'd0 and no counter flops are built. The port remains present so the interface is stable.

Decomposition:
- cpu_pkg holds:
  - opcode constants/enum (LB..BLS, 4-bit)
  - format enum (C/I/M/X_FORM)
  - fetch_state_t enum {IDLE, RUN, HALTED}
  - is_branch() function
- Sub-module next_pc_sel: combinational; inputs pc, opcode, format, jmp_loc, branch_taken; outputs next_pc and is_halt. It is reusable by a future pipelined fetch.
- fetch_sequencer holds the FSM, pc register, done pulse and counter.

Test Plan:
- Reset then start, sequential ops at pc 0..3, no stall -> pc 0,1,2,3,4 on successive cycles; instr_valid=1; instr_count=4.
- opcode=0010 at pc=5 with jmp_loc=40 -> next pc=40. Then BEQ at pc=40 with branch_taken=0 -> 41; BLS at 41 with branch_taken=1, jmp_loc=10 -> 10.
- stall=1 for 3 cycles at pc=7 with opcode=JMP -> pc stays 7 and instr_count holds. stall=0 -> pc=jmp_loc next edge.
- opcode=1110 at pc=90 -> HALTED; pc=90; done high exactly 1 cycle; halted=1. start -> pc=0, RUN.
- pc=16'hFFFF with sequential op -> pc=0; instr_count increments; no halt.
- rst_n low mid-RUN at pc=23 (async, between edges) -> pc=0, state IDLE, instr_valid=0 immediately. A start pulse restarts at 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/format encodings, fetch FSM states and decode helpers.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_LB   = 4'b0000,
        OP_SB   = 4'b0001,
        OP_JMP  = 4'b0010,
        OP_ADD  = 4'b0011,
        OP_SUB  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_OR   = 4'b0110,
        OP_XOR  = 4'b0111,
        OP_ADDI = 4'b1000,
        OP_SUBI = 4'b1001,
        OP_BNE  = 4'b1010,
        OP_BEQ  = 4'b1011,
        OP_BLT  = 4'b1100,
        OP_NOT  = 4'b1101,
        OP_HALT = 4'b1110,
        OP_BLS  = 4'b1111
    } opcode_t;

    typedef enum logic [1:0] {
        C_FORM = 2'b00,
        I_FORM = 2'b01,
        M_FORM = 2'b10,
        X_FORM = 2'b11
    } format_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    function automatic logic is_branch(input logic [3:0] op);
        return (op == OP_BNE) || (op == OP_BEQ) || (op == OP_BLT) || (op == OP_BLS);
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection for one instruction: halt, jump, taken branch or sequential.
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] pc,
    input  logic [3:0]      opcode,
    input  logic [1:0]      format,
    input  logic [PC_W-1:0] jmp_loc,
    input  logic            branch_taken,
    output logic [PC_W-1:0] next_pc,
    output logic            is_halt
);

    logic x_form;

    assign x_form = (format == X_FORM);

    // Unknown opcodes match no item and fall through to the sequential default.
    always_comb begin
        next_pc = pc + PC_W'(1);
        is_halt = 1'b0;
        case (opcode)
            OP_HALT: begin
                is_halt = 1'b1;
                next_pc = pc;
            end
            OP_JMP: begin
                if (!x_form) begin
                    next_pc = jmp_loc;
                end
            end
            default: begin
                if (is_branch(opcode) && branch_taken && !x_form) begin
                    next_pc = jmp_loc;
                end
            end
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer / fetch controller (IDLE, RUN, HALTED) driving a combinational instruction ROM.
// Define FETCH_INSTR_COUNT_EN to build the saturating retired-instruction counter.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int              PC_W       = 16,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic [3:0]      opcode,
    input  logic [1:0]      format,
    input  logic [PC_W-1:0] jmp_loc,
    input  logic            branch_taken,
    output logic [PC_W-1:0] pc,
    output logic            instr_valid,
    output logic            halted,
    output logic            done,
    output logic [31:0]     instr_count
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            done_q, done_d;
    logic [PC_W-1:0] sel_next_pc;
    logic            sel_is_halt;

    next_pc_sel #(
        .PC_W (PC_W)
    ) u_next_pc_sel (
        .pc           (pc_q),
        .opcode       (opcode),
        .format       (format),
        .jmp_loc      (jmp_loc),
        .branch_taken (branch_taken),
        .next_pc      (sel_next_pc),
        .is_halt      (sel_is_halt)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_valid = 1'b0;
        case (state_q)
            IDLE: begin
                pc_d = START_ADDR;
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // A stalled cycle retires nothing, so it outranks every redirect.
                if (!stall) begin
                    instr_valid = 1'b1;
                    pc_d        = sel_next_pc;
                    if (sel_is_halt) begin
                        state_d = HALTED;
                    end
                end
            end
            HALTED: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_ADDR;
            end
        endcase
        done_d = (state_d == HALTED) && (state_q != HALTED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
        end
    end

    assign pc     = pc_q;
    assign halted = (state_q == HALTED);
    assign done   = done_q;

`ifdef FETCH_INSTR_COUNT_EN
    logic [31:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (instr_valid && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 32'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign instr_count = count_q;
`else
    assign instr_count = 32'd0;
`endif

`ifndef SYNTHESIS
    // Unmapped ROM locations return x; they are executed as sequential ops.
    always @(posedge clk) begin
        if (rst_n && (state_q == RUN) && !stall && $isunknown(opcode)) begin
            $warning("fetch_sequencer: undefined opcode at pc=%h treated as sequential", pc_q);
        end
    end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Table-driven bench for fetch_sequencer with an expected-output scoreboard queue.
module tb_fetch_sequencer;

    typedef struct {
        logic        start;
        logic        stall;
        logic [3:0]  op;
        logic [1:0]  fmt;
        logic [15:0] jmp;
        logic        bt;
        logic [15:0] pc;
        logic        valid;
        logic        halted;
        logic        done;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic        valid;
        logic        halted;
        logic        done;
        logic [31:0] count;
    } exp_t;

`ifdef FETCH_INSTR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam logic [3:0] ADD  = 4'b0011;
    localparam logic [3:0] JMP  = 4'b0010;
    localparam logic [3:0] BEQ  = 4'b1011;
    localparam logic [3:0] BLS  = 4'b1111;
    localparam logic [3:0] HALT = 4'b1110;
    localparam logic [1:0] FC = 2'b00, FI = 2'b01, FM = 2'b10, FX = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stall;
    logic [3:0]  opcode;
    logic [1:0]  format;
    logic [15:0] jmp_loc;
    logic        branch_taken;
    logic [15:0] pc;
    logic        instr_valid;
    logic        halted;
    logic        done;
    logic [31:0] instr_count;

    int total = 0;
    int bad   = 0;
    int model_cnt = 0;
    vec_t vecs[$];
    exp_t sb[$];

    fetch_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stall        (stall),
        .opcode       (opcode),
        .format       (format),
        .jmp_loc      (jmp_loc),
        .branch_taken (branch_taken),
        .pc           (pc),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .done         (done),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(bit st, bit sl, logic [3:0] op, logic [1:0] f, logic [15:0] j,
                                bit bt, logic [15:0] epc, bit ev, bit eh, bit ed);
        vec_t r;
        r.start = st; r.stall = sl; r.op = op; r.fmt = f; r.jmp = j; r.bt = bt;
        r.pc = epc; r.valid = ev; r.halted = eh; r.done = ed;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic sl, input logic [3:0] op, input logic [1:0] f,
                         input logic [15:0] j, input logic bt);
        start = st; stall = sl; opcode = op; format = f; jmp_loc = j; branch_taken = bt;
    endtask

    initial begin
        exp_t e;
        // start stall op fmt jmp bt | pc valid halted done (outputs seen this cycle)
        vecs.push_back(mk(1, 0, ADD,  FC, 16'd0,  0, 16'd0,  0, 0, 0)); // IDLE + start
        vecs.push_back(mk(0, 0, ADD,  FC, 16'd0,  0, 16'd0,  1, 0, 0));
        vecs.push_back(mk(0, 0, ADD,  FC, 16'd0,  0, 16'd1,  1, 0, 0));
        vecs.push_back(mk(0, 0, ADD,  FC, 16'd0,  0, 16'd2,  1, 0, 0));
        vecs.push_back(mk(0, 0, ADD,  FC, 16'd0,  0, 16'd3,  1, 0, 0));
        vecs.push_back(mk(0, 0, ADD,  FC, 16'd0,  0, 16'd4,  1, 0, 0));
        vecs.push_back(mk(0, 0, JMP,  FM, 16'd40, 0, 16'd5,  1, 0, 0)); // jump to 40
        vecs.push_back(mk(0, 0, BEQ,  FI, 16'd99, 0, 16'd40, 1, 0, 0)); // not taken
        vecs.push_back(mk(0, 0, BLS,  FI, 16'd10, 1, 16'd41, 1, 0, 0)); // taken
        vecs.push_back(mk(0, 0, ADD,  FC, 16'd77, 1, 16'd10, 1, 0, 0)); // bt ignored
        vecs.push_back(mk(0, 0, JMP,  FX, 16'd50, 0, 16'd11, 1, 0, 0)); // X-form -> seq
        vecs.push_back(mk(0, 0, JMP,  FM, 16'd7,  0, 16'd12, 1, 0, 0));
        vecs.push_back(mk(0, 1, JMP,  FM, 16'd60, 0, 16'd7,  0, 0, 0)); // stall x3
        vecs.push_back(mk(0, 1, JMP,  FM, 16'd60, 0, 16'd7,  0, 0, 0));
        vecs.push_back(mk(0, 1, JMP,  FM, 16'd60, 0, 16'd7,  0, 0, 0));
        vecs.push_back(mk(0, 0, JMP,  FM, 16'd60, 0, 16'd7,  1, 0, 0));
        vecs.push_back(mk(0, 1, HALT, FX, 16'd0,  0, 16'd60, 0, 0, 0)); // stall beats halt
        vecs.push_back(mk(0, 0, BEQ,  FI, 16'd90, 1, 16'd60, 1, 0, 0));
        vecs.push_back(mk(0, 0, HALT, FX, 16'd0,  0, 16'd90, 1, 0, 0));
        vecs.push_back(mk(0, 0, ADD,  FC, 16'd0,  0, 16'd90, 0, 1, 1)); // done pulse
        vecs.push_back(mk(0, 0, ADD,  FC, 16'd0,  0, 16'd90, 0, 1, 0));
        vecs.push_back(mk(1, 0, ADD,  FC, 16'd0,  0, 16'd90, 0, 1, 0)); // restart
        vecs.push_back(mk(1, 0, ADD,  FC, 16'd0,  0, 16'd0,  1, 0, 0)); // start ignored
        vecs.push_back(mk(0, 0, JMP,  FM, 16'hFFFF, 0, 16'd1, 1, 0, 0));
        vecs.push_back(mk(0, 0, ADD,  FC, 16'd0,  0, 16'hFFFF, 1, 0, 0)); // wrap
        vecs.push_back(mk(0, 0, ADD,  FC, 16'd0,  0, 16'd0,  1, 0, 0));

        drive(0, 0, ADD, FC, 16'd0, 0);
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_valid", 32'(instr_valid), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_count", instr_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].stall, vecs[i].op, vecs[i].fmt, vecs[i].jmp, vecs[i].bt);
            e.pc = vecs[i].pc; e.valid = vecs[i].valid; e.halted = vecs[i].halted;
            e.done = vecs[i].done; e.count = CNT_EN ? 32'(model_cnt) : 32'd0;
            sb.push_back(e);
            @(negedge clk);
            e = sb.pop_front();
            $display("vec %0d: pc=%h valid=%b halted=%b done=%b count=%0d", i, pc, instr_valid,
                     halted, done, instr_count);
            chk($sformatf("v%0d_pc", i), 32'(pc), 32'(e.pc));
            chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'(e.valid));
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(e.halted));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(e.done));
            chk($sformatf("v%0d_count", i), instr_count, e.count);
            if (vecs[i].valid) model_cnt++;
            @(posedge clk);
            #1;
        end

        // Asynchronous reset between edges while running at pc=23.
        drive(0, 0, JMP, FM, 16'd23, 0);
        @(posedge clk);
        #1;
        $display("seq jmp: pc=%h", pc);
        chk("mid_pc23", 32'(pc), 32'd23);
        drive(0, 0, ADD, FC, 16'd0, 0);
        #2 rst_n = 1'b0;
        #1;
        $display("seq async reset: pc=%h valid=%b", pc, instr_valid);
        chk("areset_pc", 32'(pc), 32'd0);
        chk("areset_valid", 32'(instr_valid), 32'd0);
        chk("areset_halted", 32'(halted), 32'd0);
        chk("areset_count", instr_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        $display("seq restart: pc=%h valid=%b", pc, instr_valid);
        chk("restart_pc", 32'(pc), 32'd0);
        chk("restart_valid", 32'(instr_valid), 32'd1);
        chk("restart_count", instr_count, 32'd0);
        @(posedge clk);
        #1;
        $display("seq step: pc=%h count=%0d", pc, instr_count);
        chk("step_pc", 32'(pc), 32'd1);
        chk("step_count", instr_count, CNT_EN ? 32'd1 : 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
